tl_monitor: RTL
===============

Name: tl_monitor

Overview:
- Passive checker on the lamp side of the traffic-light controller interface: samples the r/y/g lamp drives every clock.
- Tracks the current phase and the dwell time in that phase.
- Flags sequence or timing violations with a sticky error and code, and counts completed light cycles.
- Sits beside the controller in simulation and in silicon self-test; drives nothing back into the controller.

Parameters:
- MIN_R, 4, minimum legal red dwell in clock cycles.
- MIN_G, 4, minimum legal green dwell in clock cycles.
- MIN_Y, 2, minimum legal yellow dwell in clock cycles.
- MAX_DWELL, 64, maximum legal dwell in any lit phase; must be > every MIN_x.
- DW, 8, dwell counter width; 2**DW-1 >= MAX_DWELL.
- CW, 16, completed-cycle counter width.

Ports:
- clk  in  1  single system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- r  in  1  red lamp drive from controller.
- y  in  1  yellow lamp drive from controller.
- g  in  1  green lamp drive from controller.
- phase  out  3  current tracked phase: 0 IDLE, 1 RED, 2 GREEN, 3 YELLOW, 4 ERROR.
- dwell  out  DW  cycles spent in current phase, saturating at 2**DW-1.
- cycle_cnt  out  CW  completed R->G->Y->R cycles, saturating at all-ones.
- err  out  1  sticky error flag.
- err_code  out  3  code of the first error; 0 when err=0.

Behaviour:
- Reset is synchronous, active-high, on the single clock clk. While reset=1 at a rising edge: phase=IDLE, dwell=0, cycle_cnt=0, err=0, err_code=0.
- Decoded lamp value each cycle:
  - exactly one of r/y/g high -> that colour;
  - all low -> DARK;
  - two or more high -> MULTI.
- All outputs are registered. Effect of a sample is visible the cycle after the edge that sampled it (latency 1).
- Legal transitions:
  - IDLE->IDLE on DARK; IDLE->RED on red.
  - RED->GREEN, GREEN->YELLOW, YELLOW->RED.
  - Any phase staying on the same colour is legal.
- Dwell:
  - Entering a new phase loads dwell=1.
  - Staying in the same phase increments dwell, saturating.
  - In IDLE, dwell stays 0.
- Error codes, checked on each sampled value while not in ERROR:
  - 1 MULTI: any state.
  - 2 illegal transition: e.g. RED->YELLOW, GREEN->RED, YELLOW->GREEN, IDLE->GREEN, IDLE->YELLOW.
  - 3 early exit: leaving a lit phase on a legal transition when dwell < MIN of that phase.
  - 4 timeout: staying in a lit phase when dwell = MAX_DWELL, i.e. the sample that would make dwell MAX_DWELL+1.
  - 5 DARK after any lit phase.
- Simultaneous errors: lowest code wins (MULTI beats everything).
- On error:
  - phase->ERROR; err=1; err_code latched; dwell frozen; cycle_cnt frozen.
  - ERROR is absorbing; only reset exits it.
- cycle_cnt increments on each legal, on-time YELLOW->RED transition. It does not increment on the first IDLE->RED entry.
- Early exit and timeout are checked against the phase being left, using dwell before update.
- Reset asserted mid-phase or in ERROR clears everything that cycle. The next sample is judged from IDLE.

Test Plan:
- Reset, r/y/g=0 for 5 cycles -> phase=0, dwell=0, err=0 throughout.
- R×4, G×4, Y×2, R×1 -> phase sequence 1,2,3,1, dwell=1 on each entry, cycle_cnt=1 one cycle after last R sample, err=0.
- R×4 then Y -> phase=4, err=1, err_code=2; further legal stimulus leaves outputs unchanged.
- R×4, G×3, Y -> err_code=3, dwell frozen at 3.
- R held 65 cycles -> err_code=4 on the 65th sample, dwell frozen at 64.
- Mixed cases:
  - R×2 then r=g=1: err_code=1 (also an early exit, MULTI wins).
  - R×5 then DARK: err_code=5.
  - Assert reset while in ERROR: all outputs 0 next cycle.

Source files
------------

// File: rtl/tl_monitor.sv
// Passive lamp-side checker for a traffic-light controller: tracks phase and dwell,
// latches the first sequence/timing violation, and counts completed R->G->Y->R cycles.
module tl_monitor #(
  parameter int MIN_R     = 4,
  parameter int MIN_G     = 4,
  parameter int MIN_Y     = 2,
  parameter int MAX_DWELL = 64,
  parameter int DW        = 8,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r,
  input  logic          y,
  input  logic          g,
  output logic [2:0]    phase,
  output logic [DW-1:0] dwell,
  output logic [CW-1:0] cycle_cnt,
  output logic          err,
  output logic [2:0]    err_code
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RED    = 3'd1,
    GREEN  = 3'd2,
    YELLOW = 3'd3,
    ERROR  = 3'd4
  } phase_t;

  localparam logic [DW-1:0] MAX_D = DW'(MAX_DWELL);

  phase_t        phase_reg, phase_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [CW-1:0] cycle_reg, cycle_next;
  logic          err_reg, err_next;
  logic [2:0]    code_reg, code_next;

  logic   lamp_multi, lamp_dark;
  phase_t lamp_col;
  logic   lit, stay, advance;
  logic   illegal, early, timeout, dark_err;
  logic [2:0] code_det;

  function automatic phase_t succ(input phase_t p);
    case (p)
      RED:     succ = GREEN;
      GREEN:   succ = YELLOW;
      YELLOW:  succ = RED;
      default: succ = IDLE;
    endcase
  endfunction

  function automatic logic [DW-1:0] min_dwell(input phase_t p);
    case (p)
      RED:     min_dwell = DW'(MIN_R);
      GREEN:   min_dwell = DW'(MIN_G);
      YELLOW:  min_dwell = DW'(MIN_Y);
      default: min_dwell = '0;
    endcase
  endfunction

  // Lamp decode: colour is only meaningful when neither dark nor multi.
  assign lamp_multi = (r & y) | (r & g) | (y & g);
  assign lamp_dark  = ~(r | y | g);

  always_comb begin
    lamp_col = IDLE;
    if (r)      lamp_col = RED;
    else if (g) lamp_col = GREEN;
    else if (y) lamp_col = YELLOW;
  end

  // Violation detection, judged against the phase being left and the pre-update dwell.
  always_comb begin
    lit      = (phase_reg == RED) || (phase_reg == GREEN) || (phase_reg == YELLOW);
    stay     = lit && !lamp_multi && !lamp_dark && (lamp_col == phase_reg);
    advance  = lit && !lamp_multi && !lamp_dark && (lamp_col == succ(phase_reg));
    illegal  = !lamp_multi && !lamp_dark &&
               (((phase_reg == IDLE) && (lamp_col != RED)) || (lit && !stay && !advance));
    early    = advance && (dwell_reg < min_dwell(phase_reg));
    timeout  = stay && (dwell_reg == MAX_D);
    dark_err = lit && lamp_dark;

    code_det = 3'd0;
    if (phase_reg != ERROR) begin
      if (lamp_multi)    code_det = 3'd1;
      else if (illegal)  code_det = 3'd2;
      else if (early)    code_det = 3'd3;
      else if (timeout)  code_det = 3'd4;
      else if (dark_err) code_det = 3'd5;
    end
  end

  always_comb begin
    phase_next = phase_reg;
    dwell_next = dwell_reg;
    cycle_next = cycle_reg;
    err_next   = err_reg;
    code_next  = code_reg;

    if (phase_reg == ERROR) begin
      // absorbing: everything frozen until reset
    end else if (code_det != 3'd0) begin
      phase_next = ERROR;
      err_next   = 1'b1;
      code_next  = code_det;
    end else if (phase_reg == IDLE) begin
      if (!lamp_dark) begin
        phase_next = RED;
        dwell_next = DW'(1);
      end
    end else if (stay) begin
      if (dwell_reg != '1) dwell_next = dwell_reg + 1'b1;
    end else if (advance) begin
      phase_next = lamp_col;
      dwell_next = DW'(1);
      if ((phase_reg == YELLOW) && (cycle_reg != '1)) cycle_next = cycle_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= IDLE;
      dwell_reg <= '0;
      cycle_reg <= '0;
      err_reg   <= 1'b0;
      code_reg  <= 3'd0;
    end else begin
      phase_reg <= phase_next;
      dwell_reg <= dwell_next;
      cycle_reg <= cycle_next;
      err_reg   <= err_next;
      code_reg  <= code_next;
    end
  end

  assign phase     = phase_reg;
  assign dwell     = dwell_reg;
  assign cycle_cnt = cycle_reg;
  assign err       = err_reg;
  assign err_code  = code_reg;

endmodule
